// File: rtl/crdt_grant_mgr_pkg.sv
// crdt_grant_mgr_pkg: shared mpc_types package (channel/credit types, age-offset helper)
package mpc_types;

    localparam int MAX_CH = 8;

    typedef logic [7:0]                crdt_cnt_t;
    typedef logic [$clog2(MAX_CH)-1:0] ch_id_t;

    // Distance of an LSQ index from the bottom pointer, modulo the queue size
    function automatic logic [15:0] age_off(input logic [15:0] idx, input logic [15:0] btm,
                                            input int unsigned size);
        return (idx - btm) & 16'(size - 1);
    endfunction

endpackage

// File: rtl/crdt_grant_mgr_if.sv
// crdt_grant_mgr_if: LSQ-side allocation/dealloc/credit-return bus and grant/status outputs
interface crdt_grant_mgr_if #(
    parameter int NUM_CH   = 3,
    parameter int LSQ_SIZE = 16,
    parameter int CRDT_W   = 4,
    parameter int RTN_W    = 2
);
    logic                                     alloc_valid;
    logic [$clog2(LSQ_SIZE)-1:0]              alloc_ptr;
    logic [$clog2(NUM_CH)-1:0]                alloc_ch;
    logic                                     alloc_need_crdt;
    logic [$clog2(LSQ_SIZE)-1:0]              lsq_btm_ptr;
    logic [LSQ_SIZE-1:0]                      entry_dealloc;
    logic [NUM_CH*RTN_W-1:0]                  crdt_rtn;
    logic [LSQ_SIZE-1:0]                      entry_can_execute;
    logic [NUM_CH*CRDT_W-1:0]                 crdt_cnt;
    logic [NUM_CH*($clog2(LSQ_SIZE)+1)-1:0]   pend_cnt;
    logic                                     crdt_ovf;
    logic [NUM_CH*16-1:0]                     stall_cyc;

    modport master (
        output alloc_valid, alloc_ptr, alloc_ch, alloc_need_crdt, lsq_btm_ptr, entry_dealloc, crdt_rtn,
        input  entry_can_execute, crdt_cnt, pend_cnt, crdt_ovf, stall_cyc
    );

    modport slave (
        input  alloc_valid, alloc_ptr, alloc_ch, alloc_need_crdt, lsq_btm_ptr, entry_dealloc, crdt_rtn,
        output entry_can_execute, crdt_cnt, pend_cnt, crdt_ovf, stall_cyc
    );

endinterface

// File: rtl/crdt_grant_mgr_age_picker.sv
// crdt_age_picker: combinational oldest-request selector relative to the LSQ bottom pointer
module crdt_age_picker
    import mpc_types::*;
#(
    parameter int LSQ_SIZE = 16
) (
    input  logic [LSQ_SIZE-1:0]         req_i,
    input  logic [$clog2(LSQ_SIZE)-1:0] btm_ptr_i,
    output logic [LSQ_SIZE-1:0]         pick_o,
    output logic                        vld_o
);
    logic [15:0]                 age;
    logic [15:0]                 best;
    logic [$clog2(LSQ_SIZE)-1:0] sel;

    // Linear scan keeping the requester with the smallest modulo age
    always_comb begin
        vld_o = 1'b0;
        age   = '0;
        best  = '0;
        sel   = '0;
        for (int i = 0; i < LSQ_SIZE; i++) begin
            age = age_off(16'(i), 16'(btm_ptr_i), LSQ_SIZE);
            if (req_i[i] && (!vld_o || age < best)) begin
                vld_o = 1'b1;
                best  = age;
                sel   = ($clog2(LSQ_SIZE))'(i);
            end
        end
        pick_o = vld_o ? (LSQ_SIZE'(1) << sel) : '0;
    end

endmodule

// File: rtl/crdt_grant_mgr.sv
// crdt_grant_mgr: per-channel xbar credit manager granting LSQ entries (stall counters under CRDT_GRANT_MGR_PERF_EN)
module crdt_grant_mgr
    import mpc_types::*;
#(
    parameter int NUM_CH    = 3,
    parameter int LSQ_SIZE  = 16,
    parameter int CRDT_W    = 4,
    parameter int RTN_W     = 2,
    parameter int INIT_CRDT = 8
) (
    input logic              clk,
    input logic              rst,
    crdt_grant_mgr_if.slave  lsq_if
);
    localparam int CW = $clog2(NUM_CH);
    localparam int QW = $clog2(LSQ_SIZE) + 1;
    localparam logic [CRDT_W:0] MAXC = {1'b0, {CRDT_W{1'b1}}};

    logic [LSQ_SIZE-1:0] pend_q, pend_d, grant_q, grant_d;
    logic [CW-1:0]       ent_ch_q [LSQ_SIZE];
    logic [CW-1:0]       ent_ch_d [LSQ_SIZE];
    logic [CRDT_W-1:0]   cnt_q [NUM_CH];
    logic [CRDT_W-1:0]   cnt_d [NUM_CH];
    logic [QW-1:0]       pcnt_q [NUM_CH];
    logic [QW-1:0]       pcnt_d [NUM_CH];
    logic                ovf_q, ovf_d;
    logic [CRDT_W:0]     avail [NUM_CH];
    logic [LSQ_SIZE-1:0] req [NUM_CH];
    logic [LSQ_SIZE-1:0] pick [NUM_CH];
    logic [NUM_CH-1:0]   pick_vld, byp;
    logic                hit, take;
    logic [CRDT_W:0]     sum;

    // Per-channel pending request masks and credits available this cycle (returns usable immediately)
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            avail[c] = {1'b0, cnt_q[c]} + (CRDT_W+1)'(lsq_if.crdt_rtn[c*RTN_W +: RTN_W]);
            for (int i = 0; i < LSQ_SIZE; i++)
                req[c][i] = pend_q[i] && (ent_ch_q[i] == CW'(c));
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_pick
        crdt_age_picker #(.LSQ_SIZE(LSQ_SIZE)) u_pick (
            .req_i     (req[c]),
            .btm_ptr_i (lsq_if.lsq_btm_ptr),
            .pick_o    (pick[c]),
            .vld_o     (pick_vld[c])
        );
    end

    // Bypass/pending grants, credit accounting and dealloc; alloc is applied last so it wins
    always_comb begin
        pend_d   = pend_q & ~lsq_if.entry_dealloc;
        grant_d  = grant_q & ~lsq_if.entry_dealloc;
        ent_ch_d = ent_ch_q;
        ovf_d    = ovf_q;
        byp      = '0;
        hit      = 1'b0;
        take     = 1'b0;
        sum      = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            hit    = lsq_if.alloc_valid && lsq_if.alloc_need_crdt && (lsq_if.alloc_ch == CW'(c));
            byp[c] = hit && (pcnt_q[c] == '0) && (avail[c] != '0);
            // A pick whose entry is flushed this cycle is dropped; the flush accounts for its pcnt
            take   = pick_vld[c] && (avail[c] != '0) && !byp[c] && !(|(pick[c] & lsq_if.entry_dealloc));
            if (take) begin
                pend_d  = pend_d & ~pick[c];
                grant_d = grant_d | pick[c];
            end
            sum       = avail[c] - (CRDT_W+1)'(byp[c] | take);
            cnt_d[c]  = (sum > MAXC) ? '1 : sum[CRDT_W-1:0];
            ovf_d     = ovf_d | (sum > MAXC);
            pcnt_d[c] = pcnt_q[c] + QW'(hit && !byp[c]) - QW'(take)
                        - QW'($countones(req[c] & lsq_if.entry_dealloc));
        end
        if (lsq_if.alloc_valid) begin
            ent_ch_d[lsq_if.alloc_ptr] = lsq_if.alloc_ch;
            grant_d[lsq_if.alloc_ptr]  = !lsq_if.alloc_need_crdt || (|byp);
            pend_d[lsq_if.alloc_ptr]   = lsq_if.alloc_need_crdt && !(|byp);
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q  <= '0;
            grant_q <= '0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < LSQ_SIZE; i++)
                ent_ch_q[i] <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                cnt_q[c]  <= CRDT_W'(INIT_CRDT);
                pcnt_q[c] <= '0;
            end
        end else begin
            pend_q   <= pend_d;
            grant_q  <= grant_d;
            ovf_q    <= ovf_d;
            ent_ch_q <= ent_ch_d;
            cnt_q    <= cnt_d;
            pcnt_q   <= pcnt_d;
        end
    end

    // Pack registered state onto the status outputs
    always_comb begin
        lsq_if.entry_can_execute = grant_q;
        lsq_if.crdt_ovf          = ovf_q;
        lsq_if.crdt_cnt          = '0;
        lsq_if.pend_cnt          = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            lsq_if.crdt_cnt[c*CRDT_W +: CRDT_W] = cnt_q[c];
            lsq_if.pend_cnt[c*QW +: QW]         = pcnt_q[c];
        end
    end

`ifdef CRDT_GRANT_MGR_PERF_EN
    logic [15:0] stall_q [NUM_CH];
    logic [15:0] stall_d [NUM_CH];

    // Saturating count of cycles a channel has work pending but no credit
    always_comb begin
        lsq_if.stall_cyc = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            stall_d[c] = (pcnt_q[c] != '0 && avail[c] == '0 && stall_q[c] != 16'hFFFF)
                         ? stall_q[c] + 16'd1 : stall_q[c];
            lsq_if.stall_cyc[c*16 +: 16] = stall_q[c];
        end
    end

    // Stall counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++)
                stall_q[c] <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end
`else
    assign lsq_if.stall_cyc = '0;
`endif

    ap_alloc_free: assert property (@(posedge clk) disable iff (rst)
        lsq_if.alloc_valid |-> (!(pend_q[lsq_if.alloc_ptr] || grant_q[lsq_if.alloc_ptr])
                                || lsq_if.entry_dealloc[lsq_if.alloc_ptr]));

endmodule

// File: tb/tb_crdt_grant_mgr.sv
// tb_crdt_grant_mgr: directed self-checking bench for crdt_grant_mgr (default params, INIT_CRDT=8)
module tb_crdt_grant_mgr;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [15:0] stall5;

    always #5 clk = ~clk;

    crdt_grant_mgr_if #(.NUM_CH(3), .LSQ_SIZE(16), .CRDT_W(4), .RTN_W(2)) bus ();

    crdt_grant_mgr #(.NUM_CH(3), .LSQ_SIZE(16), .CRDT_W(4), .RTN_W(2), .INIT_CRDT(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .lsq_if (bus)
    );

    function automatic logic [3:0] cnt(int c);
        return bus.crdt_cnt[c*4 +: 4];
    endfunction

    function automatic logic [4:0] pcnt(int c);
        return bus.pend_cnt[c*5 +: 5];
    endfunction

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        bus.alloc_valid   = 1'b0;
        bus.entry_dealloc = '0;
        bus.crdt_rtn      = '0;
    endtask

    task automatic alloc(int p, int c, bit need);
        bus.alloc_valid     = 1'b1;
        bus.alloc_ptr       = 4'(p);
        bus.alloc_ch        = 2'(c);
        bus.alloc_need_crdt = need;
        cyc();
    endtask

    task automatic flush(logic [15:0] m);
        bus.entry_dealloc = m;
        cyc();
    endtask

    task automatic rtn(int c, int n);
        bus.crdt_rtn[c*2 +: 2] = 2'(n);
    endtask

    // Burn n credits of channel c through bypass grants, then free the entries
    task automatic drain(int c, int n);
        flush(16'hFFFF);
        for (int i = 0; i < n; i++)
            alloc(4 + i, c, 1'b1);
        flush(16'hFFFF);
    endtask

    task automatic chk_reset(string tag);
        chk({tag, "_ece"}, 64'(bus.entry_can_execute), 64'h0);
        chk({tag, "_cnt"}, 64'(bus.crdt_cnt), 64'h888);
        chk({tag, "_pcnt"}, 64'(bus.pend_cnt), 64'h0);
        chk({tag, "_ovf"}, 64'(bus.crdt_ovf), 64'h0);
        chk({tag, "_stall"}, 64'(bus.stall_cyc), 64'h0);
    endtask

    initial begin
`ifdef CRDT_GRANT_MGR_PERF_EN
        stall5 = 16'd5;
`else
        stall5 = 16'd0;
`endif
        bus.alloc_valid     = 1'b0;
        bus.alloc_ptr       = '0;
        bus.alloc_ch        = '0;
        bus.alloc_need_crdt = 1'b0;
        bus.lsq_btm_ptr     = '0;
        bus.entry_dealloc   = '0;
        bus.crdt_rtn        = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset("rst");
        rst = 1'b0;

        alloc(3, 0, 1'b1);
        chk("byp_ece", 64'(bus.entry_can_execute), 64'h0008);
        chk("byp_cnt0", 64'(cnt(0)), 64'd7);
        alloc(12, 2, 1'b0);
        chk("nocrdt_ece", 64'(bus.entry_can_execute), 64'h1008);
        chk("nocrdt_cnt2", 64'(cnt(2)), 64'd8);

        drain(1, 7);
        chk("drain_cnt1", 64'(cnt(1)), 64'd1);
        chk("drain_cnt0", 64'(cnt(0)), 64'd7);
        alloc(0, 1, 1'b1);
        alloc(1, 1, 1'b1);
        alloc(2, 1, 1'b1);
        chk("pend_ece", 64'(bus.entry_can_execute), 64'h0001);
        chk("pend_pcnt1", 64'(pcnt(1)), 64'd2);
        chk("pend_cnt1", 64'(cnt(1)), 64'd0);
        repeat (4) cyc();
        chk("stall1", 64'(bus.stall_cyc[31:16]), 64'(stall5));
        rtn(1, 1);
        cyc();
        chk("pg1_ece", 64'(bus.entry_can_execute), 64'h0003);
        chk("pg1_pcnt1", 64'(pcnt(1)), 64'd1);
        chk("pg1_stall1", 64'(bus.stall_cyc[31:16]), 64'(stall5));
        rtn(1, 1);
        cyc();
        chk("pg2_ece", 64'(bus.entry_can_execute), 64'h0007);
        chk("pg2_pcnt1", 64'(pcnt(1)), 64'd0);
        chk("pg2_cnt1", 64'(cnt(1)), 64'd0);

        drain(2, 8);
        bus.lsq_btm_ptr = 4'd14;
        alloc(1, 2, 1'b1);
        alloc(15, 2, 1'b1);
        chk("wrap_pcnt2", 64'(pcnt(2)), 64'd2);
        rtn(2, 1);
        cyc();
        chk("wrap_first", 64'(bus.entry_can_execute), 64'h8000);
        rtn(2, 1);
        cyc();
        chk("wrap_second", 64'(bus.entry_can_execute), 64'h8002);
        chk("wrap_pcnt2b", 64'(pcnt(2)), 64'd0);
        bus.lsq_btm_ptr = 4'd0;

        drain(0, 7);
        chk("drain_cnt0b", 64'(cnt(0)), 64'd0);
        alloc(4, 0, 1'b1);
        alloc(5, 2, 1'b1);
        chk("dual_pcnt", 64'(bus.pend_cnt), 64'h0_0401);
        rtn(0, 2);
        rtn(2, 3);
        cyc();
        chk("dual_ece", 64'(bus.entry_can_execute), 64'h0030);
        chk("dual_cnt", 64'(bus.crdt_cnt), 64'h201);
        chk("dual_pcnt0", 64'(bus.pend_cnt), 64'h0);

        alloc(6, 1, 1'b1);
        chk("fl_pcnt1a", 64'(pcnt(1)), 64'd1);
        flush(16'h0040);
        chk("fl_pcnt1", 64'(pcnt(1)), 64'd0);
        chk("fl_cnt1", 64'(cnt(1)), 64'd0);
        alloc(7, 1, 1'b1);
        rtn(1, 1);
        flush(16'h0080);
        chk("flpick_ece", 64'(bus.entry_can_execute), 64'h0030);
        chk("flpick_pcnt1", 64'(pcnt(1)), 64'd0);
        chk("flpick_cnt1", 64'(cnt(1)), 64'd1);

        for (int i = 0; i < 4; i++) begin
            rtn(0, 3);
            cyc();
        end
        chk("ovf_cnt0a", 64'(cnt(0)), 64'd13);
        chk("ovf_flag_a", 64'(bus.crdt_ovf), 64'd0);
        rtn(0, 3);
        cyc();
        chk("ovf_cnt0b", 64'(cnt(0)), 64'd15);
        chk("ovf_flag_b", 64'(bus.crdt_ovf), 64'd1);
        cyc();
        chk("ovf_sticky", 64'(bus.crdt_ovf), 64'd1);
        chk("ovf_hold", 64'(cnt(0)), 64'd15);

        rst = 1'b1;
        alloc(8, 1, 1'b1);
        rst = 1'b0;
        chk_reset("midrst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
